// File: rtl/brch_resolve_unit.sv
// brch_resolve_unit: carries IF branch predictions into ID, resolves them, redirects the PC and flushes IF/ID on a mispredict
module brch_resolve_unit #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_IF_ID,
  input  logic             brch_instr_detectd_IF,
  input  logic             predict_br_taken,
  input  logic [PC_W-1:0]  pc_plus4_IF,
  input  logic [PC_W-1:0]  pred_target_IF,
  input  logic             brch_instr_detectd_ID,
  input  logic             actual_brch_result,
  input  logic [PC_W-1:0]  actual_target_ID,
  output logic             pc_redirect_valid,
  output logic [PC_W-1:0]  pc_redirect,
  output logic             flush_IF_ID,
  output logic [CNT_W-1:0] brch_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic             proto_err
);
  typedef enum logic [1:0] {IDLE, REDIRECT, SQUASH} state_t;
  state_t r_state, w_next;
  logic r_meta_vld, r_meta_taken;
  logic [PC_W-1:0] r_meta_pc4, r_meta_tgt, r_pc_redirect;
  logic [CNT_W-1:0] r_brch_cnt, r_mispred_cnt;
  logic r_proto_err;
  logic w_idle, w_resolve, w_mispred, w_orphan;
  logic [PC_W-1:0] w_correct_pc;
  always_comb begin
    w_idle       = r_state == IDLE;
    w_resolve    = brch_instr_detectd_ID & r_meta_vld & !stall_IF_ID & w_idle;
    w_orphan     = brch_instr_detectd_ID & !r_meta_vld & !stall_IF_ID & w_idle;
    w_mispred    = (r_meta_taken != actual_brch_result) |
                   (r_meta_taken & actual_brch_result & (r_meta_tgt != actual_target_ID));
    w_correct_pc = (r_meta_taken & !actual_brch_result) ? r_meta_pc4 : actual_target_ID;
    w_next       = r_state == REDIRECT ? SQUASH :
                   r_state == SQUASH   ? IDLE   :
                   (w_resolve & w_mispred) ? REDIRECT : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_meta_vld    <= 1'b0;
      r_meta_taken  <= 1'b0;
      r_meta_pc4    <= '0;
      r_meta_tgt    <= '0;
      r_pc_redirect <= '0;
      r_brch_cnt    <= '0;
      r_mispred_cnt <= '0;
      r_proto_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      // During recovery the IF slot holds wrong-path fetches, so nothing is captured
      if (!w_idle) r_meta_vld <= 1'b0;
      else if (!stall_IF_ID) begin
        r_meta_vld   <= brch_instr_detectd_IF;
        r_meta_taken <= predict_br_taken;
        r_meta_pc4   <= pc_plus4_IF;
        r_meta_tgt   <= pred_target_IF;
      end
      if (w_resolve & w_mispred) r_pc_redirect <= w_correct_pc;
      if (w_resolve & ~&r_brch_cnt) r_brch_cnt <= r_brch_cnt + 1'b1;
      if (w_resolve & w_mispred & ~&r_mispred_cnt) r_mispred_cnt <= r_mispred_cnt + 1'b1;
      if (w_orphan) r_proto_err <= 1'b1;
    end
  end
  assign pc_redirect_valid = r_state == REDIRECT;
  assign flush_IF_ID       = r_state != IDLE;
  assign pc_redirect       = r_pc_redirect;
  assign brch_cnt          = r_brch_cnt;
  assign mispred_cnt       = r_mispred_cnt;
  assign proto_err         = r_proto_err;
endmodule

// File: tb/tb_brch_resolve_unit.sv
// tb_brch_resolve_unit: directed vectors for brch_resolve_unit with CNT_W=4 so saturation is reachable
module tb_brch_resolve_unit;
  logic clk = 1'b0;
  logic rst, stall_IF_ID, brch_instr_detectd_IF, predict_br_taken;
  logic [31:0] pc_plus4_IF, pred_target_IF, actual_target_ID, pc_redirect;
  logic brch_instr_detectd_ID, actual_brch_result;
  logic pc_redirect_valid, flush_IF_ID, proto_err;
  logic [3:0] brch_cnt, mispred_cnt;
  int errors = 0;
  int checks = 0;

  brch_resolve_unit #(.PC_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .stall_IF_ID(stall_IF_ID),
    .brch_instr_detectd_IF(brch_instr_detectd_IF), .predict_br_taken(predict_br_taken),
    .pc_plus4_IF(pc_plus4_IF), .pred_target_IF(pred_target_IF),
    .brch_instr_detectd_ID(brch_instr_detectd_ID), .actual_brch_result(actual_brch_result),
    .actual_target_ID(actual_target_ID), .pc_redirect_valid(pc_redirect_valid),
    .pc_redirect(pc_redirect), .flush_IF_ID(flush_IF_ID), .brch_cnt(brch_cnt),
    .mispred_cnt(mispred_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    stall_IF_ID = 0; brch_instr_detectd_IF = 0; predict_br_taken = 0;
    pc_plus4_IF = 0; pred_target_IF = 0; brch_instr_detectd_ID = 0;
    actual_brch_result = 0; actual_target_ID = 0;
  endtask

  task automatic capture(input logic pred, input logic [31:0] pc4, input logic [31:0] tgt);
    brch_instr_detectd_IF = 1; predict_br_taken = pred; pc_plus4_IF = pc4; pred_target_IF = tgt;
    tick();
    brch_instr_detectd_IF = 0;
  endtask

  task automatic resolve(input logic act, input logic [31:0] tgt);
    brch_instr_detectd_ID = 1; actual_brch_result = act; actual_target_ID = tgt;
    tick();
    brch_instr_detectd_ID = 0;
  endtask

  initial begin
    rst = 1;
    stall_IF_ID = 1'($urandom); brch_instr_detectd_IF = 1'($urandom);
    predict_br_taken = 1'($urandom); pc_plus4_IF = $urandom; pred_target_IF = $urandom;
    brch_instr_detectd_ID = 1'($urandom); actual_brch_result = 1'($urandom);
    actual_target_ID = $urandom;
    tick(); tick();
    chk("rst_valid", 32'(pc_redirect_valid), 0);
    chk("rst_flush", 32'(flush_IF_ID), 0);
    chk("rst_pc", pc_redirect, 0);
    chk("rst_cnts", {brch_cnt, mispred_cnt}, 0);
    chk("rst_err", 32'(proto_err), 0);
    rst = 0; quiet();

    capture(1, 32'h104, 32'h100);
    resolve(1, 32'h100);
    chk("ok_valid", 32'(pc_redirect_valid), 0);
    chk("ok_flush", 32'(flush_IF_ID), 0);
    chk("ok_brch", 32'(brch_cnt), 1);
    chk("ok_mis", 32'(mispred_cnt), 0);

    capture(1, 32'h44, 32'h80);
    resolve(0, 32'h80);
    chk("a_valid", 32'(pc_redirect_valid), 1);
    chk("a_pc", pc_redirect, 32'h44);
    chk("a_flush1", 32'(flush_IF_ID), 1);
    chk("a_cnts", {brch_cnt, mispred_cnt}, {4'd2, 4'd1});
    tick();
    chk("a_sq_valid", 32'(pc_redirect_valid), 0);
    chk("a_flush2", 32'(flush_IF_ID), 1);
    tick();
    chk("a_flush3", 32'(flush_IF_ID), 0);

    capture(0, 32'h58, 32'h0);
    resolve(1, 32'h200);
    chk("b_valid", 32'(pc_redirect_valid), 1);
    chk("b_pc", pc_redirect, 32'h200);
    chk("b_mis", 32'(mispred_cnt), 2);
    tick(); tick();

    capture(1, 32'h2fc, 32'h300);
    brch_instr_detectd_ID = 1; actual_brch_result = 1; actual_target_ID = 32'h304;
    tick();
    chk("c_valid", 32'(pc_redirect_valid), 1);
    chk("c_pc", pc_redirect, 32'h304);
    chk("c_cnts", {brch_cnt, mispred_cnt}, {4'd4, 4'd3});
    tick();
    tick();
    brch_instr_detectd_ID = 0;
    chk("c_ign_cnts", {brch_cnt, mispred_cnt}, {4'd4, 4'd3});
    chk("c_ign_err", 32'(proto_err), 0);
    chk("c_ign_flush", 32'(flush_IF_ID), 0);
    chk("c_pc_hold", pc_redirect, 32'h304);

    capture(1, 32'h504, 32'h500);
    stall_IF_ID = 1; brch_instr_detectd_IF = 1; predict_br_taken = 0; pred_target_IF = 32'h999;
    brch_instr_detectd_ID = 1; actual_brch_result = 1; actual_target_ID = 32'h500;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_brch", 32'(brch_cnt), 4);
    end
    stall_IF_ID = 0; brch_instr_detectd_IF = 0;
    tick();
    brch_instr_detectd_ID = 0;
    chk("stall_rel_brch", 32'(brch_cnt), 5);
    chk("stall_rel_mis", 32'(mispred_cnt), 3);
    chk("stall_rel_valid", 32'(pc_redirect_valid), 0);
    tick();
    chk("stall_once", 32'(brch_cnt), 5);

    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 20; i++) begin
      capture(1, 32'h10, 32'h20);
      resolve(0, 32'h20);
      tick(); tick();
    end
    chk("sat_brch", 32'(brch_cnt), 15);
    chk("sat_mis", 32'(mispred_cnt), 15);
    chk("sat_err0", 32'(proto_err), 0);

    brch_instr_detectd_ID = 1;
    tick();
    brch_instr_detectd_ID = 0;
    chk("err_set", 32'(proto_err), 1);
    chk("err_valid", 32'(pc_redirect_valid), 0);
    tick(); tick();
    chk("err_sticky", 32'(proto_err), 1);

    capture(1, 32'h60, 32'h70);
    resolve(0, 32'h70);
    chk("rr_valid", 32'(pc_redirect_valid), 1);
    rst = 1;
    tick();
    chk("rr_valid0", 32'(pc_redirect_valid), 0);
    chk("rr_flush0", 32'(flush_IF_ID), 0);
    chk("rr_pc0", pc_redirect, 0);
    chk("rr_cnts0", {brch_cnt, mispred_cnt}, 0);
    chk("rr_err0", 32'(proto_err), 0);
    rst = 0;
    tick();
    chk("rr_idle", 32'(flush_IF_ID), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/brch_resolve_unit.md
Name: brch_resolve_unit

Overview:
- Consumer end of the dynamic branch-prediction interface.
- Captures the IF-stage prediction and its metadata, and carries it alongside the branch into ID.
- Compares the prediction with the resolved outcome and target in ID. On a mismatch, issues a registered PC redirect plus an IF/ID flush sequence.
- Keeps saturating branch and mispredict statistics.
- Sits between the branch predictor / IF PC mux and the ID-stage branch comparator.

Parameters:
PC_W, 32, width of PC and target buses
CNT_W, 16, width of statistics counters (saturating)

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
stall_IF_ID  input  1  IF/ID pipeline hold; metadata register holds, no resolution
brch_instr_detectd_IF  input  1  branch present in IF this cycle
predict_br_taken  input  1  predictor output for the IF branch
pc_plus4_IF  input  PC_W  fall-through PC of the IF branch
pred_target_IF  input  PC_W  target fetched under a taken prediction
brch_instr_detectd_ID  input  1  branch present in ID, resolving this cycle
actual_brch_result  input  1  resolved direction (1 = taken)
actual_target_ID  input  PC_W  resolved taken target
pc_redirect_valid  output  1  one-cycle pulse: PC mux must load pc_redirect
pc_redirect  output  PC_W  corrected fetch PC
flush_IF_ID  output  1  squash the IF/ID register contents
brch_cnt  output  CNT_W  resolved-branch count
mispred_cnt  output  CNT_W  mispredict count
proto_err  output  1  sticky: ID branch with no captured metadata

Behaviour:
- Reset (rst=1 at clk edge): state = IDLE; meta_vld = 0; all outputs 0; counters 0; proto_err 0. Reset wins over every other event, including mid-recovery.
- Metadata register (meta_vld, meta_taken, meta_pc4, meta_tgt):
  - stall_IF_ID=1: holds.
  - Flush cycle (state REDIRECT): cleared.
  - Otherwise: loads brch_instr_detectd_IF, predict_br_taken, pc_plus4_IF, pred_target_IF.
- Resolution event: brch_instr_detectd_ID & meta_vld & !stall_IF_ID & state==IDLE.
- Mispredict, evaluated on a resolution event:
  - Case a: meta_taken=1, actual=0. Correct PC = meta_pc4.
  - Case b: meta_taken=0, actual=1. Correct PC = actual_target_ID.
  - Case c: meta_taken=1, actual=1, meta_tgt != actual_target_ID. Correct PC = actual_target_ID.
  - Otherwise: no mispredict.
- Counters, on a resolution event:
  - brch_cnt +1, saturating at all-ones.
  - mispred_cnt +1 on mispredict, saturating.
- FSM states:
  - IDLE: on a mispredict, register the correct PC into pc_redirect → REDIRECT.
  - REDIRECT, one cycle: pc_redirect_valid=1, flush_IF_ID=1, meta cleared → SQUASH.
  - SQUASH, one cycle: flush_IF_ID=1. IF-side capture is suppressed (meta_vld forced 0), because the wrong-path fetch issued in the redirect cycle is in flight → IDLE.
- Latency: mispredict detected in cycle N → redirect/flush pulse in N+1 → squash in N+2 → resolution possible again in N+3.
- stall_IF_ID during REDIRECT/SQUASH: ignored. Recovery always completes in 2 cycles.
- brch_instr_detectd_ID during REDIRECT/SQUASH: ignored (wrong-path). No count, no error.
- brch_instr_detectd_ID & !meta_vld & !stall_IF_ID in IDLE: proto_err set (sticky until rst), no count, no redirect.
- Same-cycle IF capture and ID resolution: both occur. The new capture overwrites meta on the same edge, unless a mispredict moves the FSM to REDIRECT; in that case the next cycle clears meta.
- pc_redirect holds its last value when pc_redirect_valid=0.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs → all outputs 0, counters 0, FSM IDLE.
- Correct prediction: IF branch, pred=1, tgt=0x100; next cycle ID actual=1, target=0x100 → no redirect, brch_cnt=1, mispred_cnt=0.
- Case a: pred=1, pc4=0x44; actual=0 → redirect pulse next cycle with pc_redirect=0x44, flush_IF_ID high 2 cycles, mispred_cnt=1. Case b: pred=0, actual=1, target=0x200 → pc_redirect=0x200.
- Case c target mismatch: pred tgt=0x300, actual target=0x304 → pc_redirect=0x304. ID branch asserted during SQUASH is ignored and counts unchanged.
- Stall: hold stall_IF_ID 3 cycles with ID branch present → no resolution, meta held. Release → exactly one count.
- Saturation and error: CNT_W=4, 20 mispredicts → both counters stick at 15. ID branch with meta_vld=0 → proto_err=1 until rst. Assert rst during REDIRECT → next cycle IDLE, all outputs 0.
